lsu_mem_ctrl: RTL and testbench

Load/store controller between the core's execute stage and `data_mem`. Accepts one load or store per request from the pipeline, drives the `mem_in_s` valid/yumi handshake, captures the `mem_out_s` response, sign- or zero-extends byte loads, and stalls the pipeline until the transaction retires. It rejects misaligned word accesses without touching memory and flags a memory response timeout.

---
 rtl/lsu_mem_ctrl_pkg.sv | 33 +++
 rtl/lsu_mem_ctrl_if.sv | 25 ++
 rtl/lsu_mem_ctrl_load_extend.sv | 17 +
 rtl/lsu_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: memory port structs,
// FSM state encoding and the default response timeout.
package lsu_mem_ctrl_pkg;

   typedef struct packed {
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic [31:0] write_data;
      logic        yumi;
   } mem_in_s;

   typedef struct packed {
      logic        valid;
      logic [31:0] read_data;
      logic        yumi;
   } mem_out_s;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

   localparam int lsu_timeout_default_c = 64;

   // Word accesses must be 4-byte aligned; byte accesses never fault.
   function automatic logic lsu_misaligned(input logic is_byte, input logic [1:0] addr_lo);
      return !is_byte && (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Memory-side bus of the load/store controller: flattened request/response
// structs plus the request address.
interface lsu_mem_ctrl_if;
   import lsu_mem_ctrl_pkg::*;

   // Handshake: request valid stays high with stable fields until the memory
   // raises yumi in the same cycle; response valid stays high until the
   // controller raises yumi in the same cycle. Each side consumes on valid&yumi.
   logic [$bits(mem_in_s)-1:0]  mem_flat_o;
   logic [31:0]                 mem_addr_o;
   logic [$bits(mem_out_s)-1:0] mem_flat_i;

   modport master (
      output mem_flat_o,
      output mem_addr_o,
      input  mem_flat_i
   );

   modport slave (
      input  mem_flat_o,
      input  mem_addr_o,
      output mem_flat_i
   );

endinterface

// File: rtl/lsu_mem_ctrl_load_extend.sv
// Load result formatting: byte loads are sign- or zero-extended from bit 7,
// word loads pass through unchanged.
module lsu_mem_ctrl_load_extend (
   input  logic        byte_i,
   input  logic        signed_i,
   input  logic [31:0] raw_i,
   output logic [31:0] res_o
);

   always_comb begin
      res_o = raw_i;
      if (byte_i) begin
         res_o = {{24{signed_i & raw_i[7]}}, raw_i[7:0]};
      end
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: accepts one op from the pipeline, runs the
// valid/yumi exchange with data_mem and stalls the pipeline until retire.
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int timeout_p = lsu_timeout_default_c
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid_i,
   input  logic        req_wen_i,
   input  logic        req_byte_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] ld_data_o,
   output logic        err_align_o,
   output logic        err_timeout_o,
   output logic [1:0]  state_dbg_o,
   lsu_mem_ctrl_if.master mem
);

   localparam logic [1:0] ST_IDLE = LSU_IDLE;
   localparam logic [1:0] ST_REQ  = LSU_REQ;
   localparam logic [1:0] ST_WAIT = LSU_WAIT;
   localparam logic [1:0] ST_DONE = LSU_DONE;

   localparam int CNT_W = (timeout_p >= 255) ? $clog2(timeout_p + 1) : 8;
   // The abort fires on the cycle whose increment would make the count equal timeout_p.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_p - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             wen_q, wen_d;
   logic             byte_q, byte_d;
   logic             sgn_q, sgn_d;
   logic [31:0]      ld_data_q, ld_data_d;
   logic             err_align_q, err_align_d;
   logic             err_timeout_q, err_timeout_d;

   mem_in_s          mem_in;
   mem_out_s         mem_out;
   logic             mem_yumi;
   logic [31:0]      ext_data;

   assign mem_out        = mem_out_s'(mem.mem_flat_i);
   assign mem.mem_flat_o = mem_in;
   assign mem.mem_addr_o = addr_q;

   always_comb begin
      mem_in               = '0;
      mem_in.valid         = (state_q == ST_REQ);
      mem_in.wen           = wen_q;
      mem_in.byte_not_word = byte_q;
      mem_in.write_data    = wdata_q;
      mem_in.yumi          = mem_yumi;
   end

   lsu_mem_ctrl_load_extend u_load_extend (
      .byte_i   (byte_q),
      .signed_i (sgn_q),
      .raw_i    (mem_out.read_data),
      .res_o    (ext_data)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wen_d         = wen_q;
      byte_d        = byte_q;
      sgn_d         = sgn_q;
      ld_data_d     = ld_data_q;
      err_align_d   = 1'b0;
      err_timeout_d = 1'b0;
      mem_yumi      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (lsu_misaligned(req_byte_i, req_addr_i[1:0])) begin
                  err_align_d = 1'b1;
               end else begin
                  addr_d  = req_addr_i;
                  wdata_d = req_byte_i ? {24'h0, req_wdata_i[7:0]} : req_wdata_i;
                  wen_d   = req_wen_i;
                  byte_d  = req_byte_i;
                  sgn_d   = req_signed_i;
                  cnt_d   = '0;
                  state_d = ST_REQ;
               end
            end
         end

         ST_REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else if (mem_out.yumi) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Timeout wins over a same-cycle response, so the response is left unconsumed.
            if (cnt_q == CNT_LAST) begin
               err_timeout_d = 1'b1;
               state_d       = ST_IDLE;
            end else if (mem_out.valid) begin
               mem_yumi  = 1'b1;
               ld_data_d = wen_q ? 32'h0 : ext_data;
               state_d   = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wen_q         <= 1'b0;
         byte_q        <= 1'b0;
         sgn_q         <= 1'b0;
         ld_data_q     <= '0;
         err_align_q   <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wen_q         <= wen_d;
         byte_q        <= byte_d;
         sgn_q         <= sgn_d;
         ld_data_q     <= ld_data_d;
         err_align_q   <= err_align_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign done_o        = (state_q == ST_DONE);
   assign ld_data_o     = ld_data_q;
   assign err_align_o   = err_align_q;
   assign err_timeout_o = err_timeout_q;
   assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a byte-array data_mem model whose
// yumi and response delays are adjustable per scenario.
module tb_lsu_mem_ctrl;
   import lsu_mem_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_wen = 1'b0;
   logic        req_byte = 1'b0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        busy_o, done_o, err_align_o, err_timeout_o;
   logic [31:0] ld_data_o;
   logic [1:0]  state_dbg_o;

   int checks = 0;
   int errors = 0;

   lsu_mem_ctrl_if mbus ();

   lsu_mem_ctrl #(.timeout_p(64)) dut (
      .clk           (clk),
      .reset         (rst),
      .req_valid_i   (req_valid),
      .req_wen_i     (req_wen),
      .req_byte_i    (req_byte),
      .req_signed_i  (req_signed),
      .req_addr_i    (req_addr),
      .req_wdata_i   (req_wdata),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .ld_data_o     (ld_data_o),
      .err_align_o   (err_align_o),
      .err_timeout_o (err_timeout_o),
      .state_dbg_o   (state_dbg_o),
      .mem           (mbus)
   );

   always #5 clk = ~clk;

   // ---------------- data_mem model ----------------
   logic [7:0]  mem_arr [0:1023];
   mem_in_s     m_in;
   mem_out_s    m_out;
   int          yumi_delay = 0;
   int          resp_delay = 0;
   int          req_cnt;
   int          resp_cnt;
   logic        pending;
   logic [31:0] rdata_q;
   logic [31:0] last_wdata;
   logic [9:0]  ma;

   assign m_in            = mbus.mem_flat_o;
   assign mbus.mem_flat_i = m_out;
   assign ma              = mbus.mem_addr_o[9:0];

   always_comb begin
      m_out           = '0;
      m_out.yumi      = m_in.valid && (req_cnt >= yumi_delay);
      m_out.valid     = pending && (resp_cnt >= resp_delay);
      m_out.read_data = m_out.valid ? rdata_q : 32'h0;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pending      <= 1'b0;
         req_cnt      <= 0;
         resp_cnt     <= 0;
         rdata_q      <= '0;
         last_wdata   <= '0;
         mem_arr[64]  <= 8'hEF;
         mem_arr[65]  <= 8'hBE;
         mem_arr[66]  <= 8'hAD;
         mem_arr[67]  <= 8'hDE;
      end else begin
         if (m_in.valid && m_out.yumi) begin
            req_cnt    <= 0;
            pending    <= 1'b1;
            resp_cnt   <= 0;
            last_wdata <= m_in.write_data;
            if (m_in.wen) begin
               rdata_q <= '0;
               if (m_in.byte_not_word) begin
                  mem_arr[ma] <= m_in.write_data[7:0];
               end else begin
                  mem_arr[ma]          <= m_in.write_data[7:0];
                  mem_arr[ma + 10'd1]  <= m_in.write_data[15:8];
                  mem_arr[ma + 10'd2]  <= m_in.write_data[23:16];
                  mem_arr[ma + 10'd3]  <= m_in.write_data[31:24];
               end
            end else if (m_in.byte_not_word) begin
               rdata_q <= {24'h0, mem_arr[ma]};
            end else begin
               rdata_q <= {mem_arr[ma + 10'd3], mem_arr[ma + 10'd2], mem_arr[ma + 10'd1], mem_arr[ma]};
            end
         end else begin
            if (m_in.valid) req_cnt <= req_cnt + 1;
            if (pending) begin
               if (m_out.valid && m_in.yumi) pending <= 1'b0;
               else resp_cnt <= resp_cnt + 1;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_op(input logic wen, input logic byt, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int budget,
                         output int lat, output logic [31:0] data, output logic addr_held,
                         output logic got_done, output logic got_to, output int vcnt);
      @(posedge clk);
      #1;
      req_wen    = wen;
      req_byte   = byt;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 0; data = '0; addr_held = 1'b1; got_done = 1'b0; got_to = 1'b0; vcnt = 0;
      while (lat < budget && !got_done && !got_to) begin
         @(negedge clk);
         lat++;
         if (busy_o && mbus.mem_addr_o !== addr) addr_held = 1'b0;
         if (m_in.valid) vcnt++;
         if (done_o) begin
            got_done = 1'b1;
            data     = ld_data_o;
         end
         if (err_timeout_o) got_to = 1'b1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || err_align_o !== 1'b0 || err_timeout_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: busy=%b done=%b align=%b to=%b, required all 0", busy_o, done_o, err_align_o, err_timeout_o);
      end
      checks++;
      if (mbus.mem_flat_o !== '0 || mbus.mem_addr_o !== 32'h0 || ld_data_o !== 32'h0 || state_dbg_o !== 2'd0) begin
         errors++;
         $display("FAIL reset_bus: flat=%h addr=%h ld=%h st=%0d, required 0", mbus.mem_flat_o, mbus.mem_addr_o, ld_data_o, state_dbg_o);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_word_load();
      int lat, vc; logic [31:0] d; logic ah, gd, gt;
      run_op(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || lat != 3) begin
         errors++;
         $display("FAIL word_load_latency: done=%b at cycle %0d, required done at cycle 3", gd, lat);
      end
      checks++;
      if (d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL word_load_data: got %h, required deadbeef", d);
      end
      checks++;
      if (!ah || vc != 1) begin
         errors++;
         $display("FAIL word_load_bus: addr_held=%b valid_cycles=%0d, required 1 and 1", ah, vc);
      end
   endtask

   task automatic test_byte_load();
      int lat, vc; logic [31:0] d; logic ah, gd, gt;
      run_op(1'b1, 1'b1, 1'b0, 32'h41, 32'hAAAAAA9C, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || d !== 32'h0 || last_wdata !== 32'h0000009C) begin
         errors++;
         $display("FAIL byte_store: done=%b ld=%h wdata=%h, required 1 00000000 0000009c", gd, d, last_wdata);
      end
      run_op(1'b0, 1'b1, 1'b1, 32'h41, 32'h0, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || d !== 32'hFFFFFF9C) begin
         errors++;
         $display("FAIL byte_load_signed: done=%b got %h, required ffffff9c", gd, d);
      end
      run_op(1'b0, 1'b1, 1'b0, 32'h41, 32'h0, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || d !== 32'h0000009C) begin
         errors++;
         $display("FAIL byte_load_unsigned: done=%b got %h, required 0000009c", gd, d);
      end
      run_op(1'b0, 1'b1, 1'b1, 32'h43, 32'h0, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || d !== 32'hFFFFFFDE) begin
         errors++;
         $display("FAIL byte_load_odd_addr: done=%b got %h, required ffffffde", gd, d);
      end
   endtask

   task automatic test_store_load();
      int lat, vc; logic [31:0] d; logic ah, gd, gt;
      run_op(1'b1, 1'b0, 1'b0, 32'h80, 32'h12345678, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || lat != 3 || d !== 32'h0) begin
         errors++;
         $display("FAIL word_store: done=%b cycle=%0d ld=%h, required 1 3 00000000", gd, lat, d);
      end
      run_op(1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || d !== 32'h12345678) begin
         errors++;
         $display("FAIL store_readback: done=%b got %h, required 12345678", gd, d);
      end
   endtask

   task automatic test_align();
      logic saw_valid;
      saw_valid = 1'b0;
      @(posedge clk);
      #1;
      req_wen = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 32'h42; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      if (m_in.valid) saw_valid = 1'b1;
      checks++;
      if (err_align_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL align_pulse: err_align=%b busy=%b, required 1 0", err_align_o, busy_o);
      end
      @(negedge clk);
      if (m_in.valid) saw_valid = 1'b1;
      checks++;
      if (err_align_o !== 1'b0 || busy_o !== 1'b0 || saw_valid) begin
         errors++;
         $display("FAIL align_after: err_align=%b busy=%b mem_valid_seen=%b, required 0 0 0", err_align_o, busy_o, saw_valid);
      end
   endtask

   task automatic test_timeout();
      int lat, vc; logic [31:0] d; logic ah, gd, gt;
      resp_delay = 100;
      run_op(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 100, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gt || gd || lat != 65 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort: to=%b done=%b cycle=%0d busy=%b, required 1 0 65 0", gt, gd, lat, busy_o);
      end
      @(negedge clk);
      checks++;
      if (err_timeout_o !== 1'b0 || done_o !== 1'b0 || state_dbg_o !== 2'd0) begin
         errors++;
         $display("FAIL timeout_pulse_end: to=%b done=%b st=%0d, required 0 0 0", err_timeout_o, done_o, state_dbg_o);
      end
      apply_reset();
      resp_delay = 62;
      run_op(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 100, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gt || gd || lat != 65) begin
         errors++;
         $display("FAIL timeout_priority: to=%b done=%b cycle=%0d, required 1 0 65", gt, gd, lat);
      end
      apply_reset();
      resp_delay = 61;
      run_op(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 100, lat, d, ah, gd, gt, vc);
      checks++;
      if (gt || !gd || lat != 64 || d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL timeout_just_in: to=%b done=%b cycle=%0d data=%h, required 0 1 64 deadbeef", gt, gd, lat, d);
      end
      resp_delay = 0;
   endtask

   task automatic test_yumi_delay();
      int lat, vc; logic [31:0] d; logic ah, gd, gt;
      yumi_delay = 5;
      run_op(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 30, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || lat != 8 || d !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL yumi_delay_done: done=%b cycle=%0d data=%h, required 1 8 deadbeef", gd, lat, d);
      end
      checks++;
      if (!ah || vc != 6) begin
         errors++;
         $display("FAIL yumi_delay_hold: addr_held=%b valid_cycles=%0d, required 1 6", ah, vc);
      end
      yumi_delay = 0;
   endtask

   task automatic test_reset_mid();
      int lat, vc; logic [31:0] d; logic ah, gd, gt;
      resp_delay = 20;
      @(posedge clk);
      #1;
      req_wen = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 32'h80; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (state_dbg_o !== 2'd2 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_setup: state=%0d busy=%b, required 2 1", state_dbg_o, busy_o);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || ld_data_o !== 32'h0 || mbus.mem_flat_o !== '0 || mbus.mem_addr_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_async: busy=%b done=%b ld=%h flat=%h addr=%h, required all 0", busy_o, done_o, ld_data_o, mbus.mem_flat_o, mbus.mem_addr_o);
      end
      @(negedge clk);
      rst = 1'b0;
      resp_delay = 0;
      run_op(1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 20, lat, d, ah, gd, gt, vc);
      checks++;
      if (!gd || lat != 3 || d !== 32'h12345678) begin
         errors++;
         $display("FAIL reset_mid_recover: done=%b cycle=%0d data=%h, required 1 3 12345678", gd, lat, d);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] done_mask;
      logic        bad_data;
      done_mask = '0;
      bad_data  = 1'b0;
      @(posedge clk);
      #1;
      req_wen = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (done_o) begin
            done_mask[c] = 1'b1;
            if (ld_data_o !== 32'hDEADBEEF) bad_data = 1'b1;
         end
         if (c == 11) req_valid = 1'b0;
      end
      checks++;
      if (done_mask !== 16'h0888 || bad_data) begin
         errors++;
         $display("FAIL back_to_back: done_mask=%h bad_data=%b, required 0888 0", done_mask, bad_data);
      end
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL back_to_back_idle: busy=%b done=%b, required 0 0", busy_o, done_o);
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_store_load();
      test_align();
      test_timeout();
      apply_reset();
      test_yumi_delay();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
